// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, functs,
// ALU control codes, FSM state codes and the per-state strobe bundle.
package mc_controller_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CTL_W   = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [CTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTL_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [STATE_W-1:0] S_RST    = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH  = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE = 4'd2;
  localparam logic [STATE_W-1:0] S_MEMADR = 4'd3;
  localparam logic [STATE_W-1:0] S_MEMRD  = 4'd4;
  localparam logic [STATE_W-1:0] S_MEMWB  = 4'd5;
  localparam logic [STATE_W-1:0] S_MEMWR  = 4'd6;
  localparam logic [STATE_W-1:0] S_RTEX   = 4'd7;
  localparam logic [STATE_W-1:0] S_RTWB   = 4'd8;
  localparam logic [STATE_W-1:0] S_BEQEX  = 4'd9;
  localparam logic [STATE_W-1:0] S_ADDIEX = 4'd10;
  localparam logic [STATE_W-1:0] S_ADDIWB = 4'd11;
  localparam logic [STATE_W-1:0] S_JEX    = 4'd12;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU decoder: maps aluop (and funct for R-type) to the 4-bit
// alucontrol code; funct_ok flags an unsupported R-type funct.
module mc_controller_alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [1:0]       aluop,
  input  logic [OP_W-1:0]  funct,
  output logic [CTL_W-1:0] alucontrol,
  output logic             funct_ok
);

  always_comb begin
    alucontrol = ALU_ADD;
    funct_ok   = 1'b1;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: funct_ok   = 1'b0;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM stepping each instruction phase
// and driving the datapath strobes plus alucontrol for the downstream ALU.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [OP_W-1:0]  op,
  input  logic [OP_W-1:0]  funct,
  input  logic             zero,
  output logic             pcen,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [CTL_W-1:0] alucontrol,
  output logic             illegal
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [1:0]         aluop;
  logic [CTL_W-1:0]   dec_ctl;
  logic               funct_ok;
  ctrl_t              ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RST;
    else          state_q <= state_d;
  end

  // aluop kept outside the strobe block so funct_ok feeds back without a loop
  always_comb begin
    aluop = ALUOP_ADD;
    if (state_q == S_RTEX)  aluop = ALUOP_FUNCT;
    if (state_q == S_BEQEX) aluop = ALUOP_SUB;
  end

  mc_controller_alu_decoder u_alu_dec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (dec_ctl),
    .funct_ok   (funct_ok)
  );

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        state_d      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_RTEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.illegal = ~funct_ok;
        state_d      = funct_ok ? S_RTWB : S_FETCH;
      end
      S_RTWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
        state_d      = S_FETCH;
      end
      default:  state_d = S_RST;
    endcase
  end

  assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
  assign iord       = ctrl.iord;
  assign memwrite   = ctrl.memwrite;
  assign irwrite    = ctrl.irwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign illegal    = ctrl.illegal;
  assign alucontrol = (state_q == S_RST) ? '0 : dec_ctl;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: per-cycle compare against an
// instruction-level model plus literal checks on directed instructions.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // [16]pcen [15]iord [14]memwrite [13]irwrite [12]regdst [11]memtoreg
  // [10]regwrite [9]alusrca [8:7]alusrcb [6:5]pcsrc [4:1]alucontrol [0]illegal
  logic [16:0] act;
  assign act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, alucontrol, illegal};

  int n_checks = 0;
  int n_fail   = 0;

  logic        check_en = 1'b0;
  logic        in_rst   = 1'b1;
  logic [5:0]  cur_op   = 6'd0;
  logic [5:0]  cur_fn   = 6'd0;
  int          step     = 0;
  logic [16:0] trace [8];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit rt_ok(input logic [5:0] f);
    return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
  endfunction

  function automatic logic [3:0] rt_ctl(input logic [5:0] f);
    case (f)
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2a:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  // Edges spent on one instruction, counting the FETCH cycle
  function automatic int instr_len(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return rt_ok(f) ? 4 : 3;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // Expected outputs for cycle s of instruction (o,f), as a datapath recipe
  function automatic logic [16:0] expect_out(input logic rst, input logic [5:0] o,
                                             input logic [5:0] f, input int s, input logic z);
    logic pw, br, io, mw, ir, rd, mr, rw, sa, il;
    logic [1:0] sb, ps;
    logic [3:0] ctl;
    if (rst) return 17'd0;
    {pw, br, io, mw, ir, rd, mr, rw, sa, il} = '0;
    sb = 2'b00; ps = 2'b00; ctl = 4'b0010;
    if (s == 0) begin
      ir = 1; pw = 1; sb = 2'b01;
    end else if (s == 1) begin
      sb = 2'b11;
      il = (instr_len(o, f) == 2);
    end else begin
      case (o)
        6'b100011: begin
          if (s == 2) begin sa = 1; sb = 2'b10; end
          if (s == 3) io = 1;
          if (s == 4) begin mr = 1; rw = 1; end
        end
        6'b101011: begin
          if (s == 2) begin sa = 1; sb = 2'b10; end
          if (s == 3) begin io = 1; mw = 1; end
        end
        6'b000000: begin
          if (s == 2) begin sa = 1; ctl = rt_ctl(f); il = !rt_ok(f); end
          if (s == 3) begin rd = 1; rw = 1; end
        end
        6'b000100: begin sa = 1; ctl = 4'b0110; ps = 2'b01; br = 1; end
        6'b001000: begin
          if (s == 2) begin sa = 1; sb = 2'b10; end
          if (s == 3) rw = 1;
        end
        6'b000010: begin ps = 2'b10; pw = 1; end
        default: ;
      endcase
    end
    return {pw | (br & z), io, mw, ir, rd, mr, rw, sa, sb, ps, ctl, il};
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      logic [16:0] e;
      e = expect_out(in_rst, cur_op, cur_fn, step, zero);
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL cycle op=%b fn=%b step=%0d: got %b expected %b at %0t",
                 cur_op, cur_fn, step, act, e, $time);
      end
    end
  end

  // Runs one instruction from FETCH; abort>=0 pulls reset mid-cycle at that step
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input int abort);
    int n;
    cur_op = o; cur_fn = f; op = o; funct = f;
    n = instr_len(o, f);
    for (int s = 0; s < n; s++) begin
      step = s;
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      #1 trace[s] = act;
      if (s == abort) begin
        #1 reset_n = 1'b0; in_rst = 1'b1;
        #1 chk("reset_async_zero", int'(act), 0);
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic release_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1 in_rst = 1'b0; step = 0;
    chk("fetch_after_reset", int'({irwrite, pcen, alusrcb, alucontrol}), 'b11_01_0010);
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
    check_en = 1'b1;
    @(posedge clk); #1;
    chk("reset_state_zero", int'(act), 0);
    release_reset();

    run_instr(6'b100011, 6'h15, 2, -1);
    chk("lw_memadr", int'({trace[2][8:7], trace[2][4:1]}), 'b10_0010);
    chk("lw_memrd_iord", int'(trace[3][15]), 1);
    chk("lw_memwb", int'({trace[4][11], trace[4][10]}), 'b11);

    run_instr(6'b101011, 6'h00, 2, -1);
    chk("sw_memwr", int'({trace[3][14], trace[3][15]}), 'b11);
    chk("sw_no_regwrite", int'({trace[0][10], trace[1][10], trace[2][10], trace[3][10]}), 0);

    run_instr(6'b000000, 6'b101010, 2, -1);
    chk("rt_slt_ctl", int'(trace[2][4:1]), 'b0111);
    chk("rt_wb", int'({trace[3][12], trace[3][10]}), 'b11);

    run_instr(6'b000000, 6'b000000, 2, -1);
    chk("rt_bad_funct", int'({trace[2][0], trace[2][10], trace[2][4:1]}), 'b1_0_0010);

    run_instr(6'b000100, 6'h00, 1, -1);
    chk("beq_taken", int'({trace[2][4:1], trace[2][6:5], trace[2][16]}), 'b0110_01_1);
    run_instr(6'b000100, 6'h00, 0, -1);
    chk("beq_not_taken", int'(trace[2][16]), 0);

    run_instr(6'b111111, 6'h20, 2, -1);
    chk("illegal_op_pulse", int'(trace[1][0]), 1);

    run_instr(6'b000010, 6'h00, 2, -1);
    chk("jump", int'({trace[2][6:5], trace[2][16]}), 'b10_1);

    run_instr(6'b100011, 6'h00, 2, 3);
    release_reset();

    for (int i = 0; i < 300; i++) begin
      logic [5:0] o, f;
      int k;
      k = $urandom_range(0, 6);
      o = (k == 6) ? 6'($urandom) : ops[k];
      f = ($urandom_range(0, 1) == 1) ? 6'($urandom) : rt_ok_pick($urandom_range(0, 4));
      if ($urandom_range(0, 40) == 0) begin
        run_instr(o, f, 2, $urandom_range(0, instr_len(o, f) - 1));
        release_reset();
      end else begin
        run_instr(o, f, 2, -1);
      end
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [5:0] rt_ok_pick(input int unsigned idx);
    case (idx)
      0:       return 6'h20;
      1:       return 6'h22;
      2:       return 6'h24;
      3:       return 6'h25;
      default: return 6'h2a;
    endcase
  endfunction

endmodule
